// File: rtl/debug_pkg.sv
// Shared definitions for the debug command sequencer and the debug unit:
// GPIO opcodes, command word field layout, host command codes, FSM states.
package debug_pkg;

    // Command word field layout: [31] enable, [22:16] opcode, [15:0] data
    localparam int POS_ENABLE = 31;
    localparam int POS_ADDR   = 16;
    localparam int NB_ADDR    = 7;
    localparam int NB_HALF    = 16;

    // Debug unit opcodes (opcode 0 is the idle / no-op word)
    localparam logic [NB_ADDR-1:0] OP_CLEAR_ALL    = 7'd10;
    localparam logic [NB_ADDR-1:0] OP_STEP_ARM     = 7'd11;
    localparam logic [NB_ADDR-1:0] OP_STEP_GO      = 7'd12;
    localparam logic [NB_ADDR-1:0] OP_RUN          = 7'd13;
    localparam logic [NB_ADDR-1:0] OP_HALT         = 7'd14;
    localparam logic [NB_ADDR-1:0] OP_IADDR_LO     = 7'd15;
    localparam logic [NB_ADDR-1:0] OP_IADDR_HI     = 7'd16;
    localparam logic [NB_ADDR-1:0] OP_IDATA_LO     = 7'd17;
    localparam logic [NB_ADDR-1:0] OP_IDATA_HI     = 7'd18;
    localparam logic [NB_ADDR-1:0] OP_IWRITE       = 7'd19;
    localparam logic [NB_ADDR-1:0] OP_ICOMMIT      = 7'd20;
    localparam logic [NB_ADDR-1:0] OP_REG_SEL      = 7'd21;
    localparam logic [NB_ADDR-1:0] OP_MADDR_LO     = 7'd22;
    localparam logic [NB_ADDR-1:0] OP_MADDR_HI     = 7'd23;
    localparam logic [NB_ADDR-1:0] OP_REG_READ     = 7'd24;
    localparam logic [NB_ADDR-1:0] OP_MEM_READ     = 7'd29;
    localparam logic [NB_ADDR-1:0] OP_PC_READ      = 7'd30;
    localparam logic [NB_ADDR-1:0] OP_CPU_RST_SET  = 7'd31;
    localparam logic [NB_ADDR-1:0] OP_CPU_RST_CLR  = 7'd32;

    // Host command codes
    localparam logic [2:0] CMD_LOAD_INSTR = 3'd0;
    localparam logic [2:0] CMD_READ_REG   = 3'd1;
    localparam logic [2:0] CMD_READ_MEM   = 3'd2;
    localparam logic [2:0] CMD_READ_PC    = 3'd3;
    localparam logic [2:0] CMD_STEP       = 3'd4;
    localparam logic [2:0] CMD_RUN        = 3'd5;
    localparam logic [2:0] CMD_HALT       = 3'd6;
    localparam logic [2:0] CMD_RESET_CPU  = 3'd7;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Commands that return a readback word
    function automatic logic is_read_cmd(input logic [2:0] cmd);
        return (cmd == CMD_READ_REG) || (cmd == CMD_READ_MEM) || (cmd == CMD_READ_PC);
    endfunction

endpackage

// File: rtl/debug_uop_rom.sv
// Micro-op table: maps (command, step index) to the opcode and 16-bit payload
// of one GPIO command word, plus flags for the last step and readback capture.
module debug_uop_rom
    import debug_pkg::*;
#(
    parameter int NB_GPIO = 32
) (
    input  logic [2:0]         cmd,
    input  logic [2:0]         step,
    input  logic [NB_GPIO-1:0] addr,
    input  logic [NB_GPIO-1:0] data,
    output logic [NB_ADDR-1:0] opcode,
    output logic [NB_HALF-1:0] uop_data,
    output logic               last,
    output logic               capture
);

    // Decode the current micro-op; unlisted steps fall back to a harmless last no-op
    always_comb begin
        opcode   = '0;
        uop_data = '0;
        last     = 1'b1;
        capture  = 1'b0;
        case (cmd)
            CMD_LOAD_INSTR: begin
                last = 1'b0;
                case (step)
                    3'd0: begin opcode = OP_IADDR_LO; uop_data = addr[NB_HALF-1:0]; end
                    3'd1: begin opcode = OP_IADDR_HI; uop_data = addr[2*NB_HALF-1:NB_HALF]; end
                    3'd2: begin opcode = OP_IDATA_LO; uop_data = data[NB_HALF-1:0]; end
                    3'd3: begin opcode = OP_IDATA_HI; uop_data = data[2*NB_HALF-1:NB_HALF]; end
                    3'd4: opcode = OP_IWRITE;
                    default: begin opcode = OP_ICOMMIT; last = 1'b1; end
                endcase
            end
            CMD_READ_REG: begin
                if (step == 3'd0) begin
                    opcode   = OP_REG_SEL;
                    uop_data = {11'b0, addr[4:0]};
                    last     = 1'b0;
                end else begin
                    opcode  = OP_REG_READ;
                    capture = 1'b1;
                end
            end
            CMD_READ_MEM: begin
                case (step)
                    3'd0: begin opcode = OP_MADDR_LO; uop_data = addr[NB_HALF-1:0]; last = 1'b0; end
                    3'd1: begin opcode = OP_MADDR_HI; uop_data = addr[2*NB_HALF-1:NB_HALF]; last = 1'b0; end
                    default: begin opcode = OP_MEM_READ; capture = 1'b1; end
                endcase
            end
            CMD_READ_PC: begin
                opcode  = OP_PC_READ;
                capture = 1'b1;
            end
            CMD_STEP: begin
                if (step == 3'd0) begin
                    opcode = OP_STEP_ARM;
                    last   = 1'b0;
                end else begin
                    opcode = OP_STEP_GO;
                end
            end
            CMD_RUN:  opcode = OP_RUN;
            CMD_HALT: opcode = OP_HALT;
            default: begin
                if (step == 3'd0) begin
                    opcode = OP_CPU_RST_SET;
                    last   = 1'b0;
                end else begin
                    opcode = OP_CPU_RST_CLR;
                end
            end
        endcase
    end

endmodule

// File: rtl/debug_cmd_sequencer.sv
// Expands one host debug command into the ordered GPIO command words for the
// debug unit. Each word is held HOLD_CYCLES cycles followed by one idle word;
// read commands capture the readback on the last hold cycle of the capture op.
module debug_cmd_sequencer
    import debug_pkg::*;
#(
    parameter int NB_GPIO     = 32,
    parameter int HOLD_CYCLES = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [2:0]         i_cmd,
    input  logic [NB_GPIO-1:0] i_cmd_addr,
    input  logic [NB_GPIO-1:0] i_cmd_data,
    output logic [NB_GPIO-1:0] o_gpio,
    input  logic [NB_GPIO-1:0] i_gpio,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_rsp_valid,
    output logic [NB_GPIO-1:0] o_rsp_data
);

    // The readback lags the opcode by one cycle, so a hold of 2 is the floor
    localparam int HOLD_EFF = (HOLD_CYCLES < 2) ? 2 : HOLD_CYCLES;
    localparam int NB_HOLD  = $clog2(HOLD_EFF + 1);
    localparam logic [NB_HOLD-1:0] HOLD_FIRST = NB_HOLD'(1);
    localparam logic [NB_HOLD-1:0] HOLD_LAST  = NB_HOLD'(HOLD_EFF);

    state_t             state;
    logic [2:0]         cmd_q;
    logic [2:0]         step_q;
    logic [NB_GPIO-1:0] addr_q;
    logic [NB_GPIO-1:0] data_q;
    logic [NB_HOLD-1:0] hold_cnt;
    logic               last_q;
    logic               capture_q;
    logic               accept;

    logic [2:0]         rom_cmd;
    logic [2:0]         rom_step;
    logic [NB_GPIO-1:0] rom_addr;
    logic [NB_GPIO-1:0] rom_data;
    logic [NB_ADDR-1:0] uop_opcode;
    logic [NB_HALF-1:0] uop_data;
    logic               uop_last;
    logic               uop_capture;
    logic [NB_GPIO-1:0] uop_word;

    function automatic logic [NB_GPIO-1:0] make_word(input logic [NB_ADDR-1:0] op,
                                                     input logic [NB_HALF-1:0] payload);
        logic [NB_GPIO-1:0] w;
        w                        = '0;
        w[POS_ENABLE]            = 1'b1;
        w[POS_ADDR +: NB_ADDR]   = op;
        w[NB_HALF-1:0]           = payload;
        return w;
    endfunction

    assign accept   = (state == ST_IDLE) && i_cmd_valid && o_cmd_ready;
    assign uop_word = make_word(uop_opcode, uop_data);

    // ROM looks at the live inputs while idle (first word goes out on the accept edge)
    // and one step ahead while in the gap (next word goes out on the gap exit edge)
    always_comb begin
        rom_cmd  = cmd_q;
        rom_step = step_q;
        rom_addr = addr_q;
        rom_data = data_q;
        if (state == ST_IDLE) begin
            rom_cmd  = i_cmd;
            rom_step = 3'd0;
            rom_addr = i_cmd_addr;
            rom_data = i_cmd_data;
        end else if (state == ST_GAP) begin
            rom_step = step_q + 3'd1;
        end
    end

    debug_uop_rom #(
        .NB_GPIO (NB_GPIO)
    ) u_rom (
        .cmd      (rom_cmd),
        .step     (rom_step),
        .addr     (rom_addr),
        .data     (rom_data),
        .opcode   (uop_opcode),
        .uop_data (uop_data),
        .last     (uop_last),
        .capture  (uop_capture)
    );

    // Command operands are frozen at accept so input changes mid-sequence are ignored
    always_ff @(posedge i_clock) begin
        if (accept) begin
            cmd_q  <= i_cmd;
            addr_q <= i_cmd_addr;
            data_q <= i_cmd_data;
        end
    end

    // Sequencer FSM with registered outputs aligned to the state
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            step_q      <= '0;
            hold_cnt    <= '0;
            last_q      <= 1'b0;
            capture_q   <= 1'b0;
            o_gpio      <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_cmd_ready <= 1'b1;
        end else begin
            o_done      <= 1'b0;
            o_rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_ISSUE;
                        step_q      <= '0;
                        hold_cnt    <= HOLD_FIRST;
                        o_gpio      <= uop_word;
                        last_q      <= uop_last;
                        capture_q   <= uop_capture;
                        o_busy      <= 1'b1;
                        o_cmd_ready <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state  <= ST_GAP;
                        o_gpio <= '0;
                        if (capture_q) begin
                            o_rsp_data <= i_gpio;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_FIRST;
                    end
                end
                ST_GAP: begin
                    if (last_q) begin
                        state       <= ST_DONE;
                        o_done      <= 1'b1;
                        o_rsp_valid <= is_read_cmd(cmd_q);
                    end else begin
                        state     <= ST_ISSUE;
                        step_q    <= step_q + 3'd1;
                        hold_cnt  <= HOLD_FIRST;
                        o_gpio    <= uop_word;
                        last_q    <= uop_last;
                        capture_q <= uop_capture;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    o_busy      <= 1'b0;
                    o_cmd_ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Directed bench for debug_cmd_sequencer with HOLD_CYCLES = 2. Cycle c below is
// the c-th clock period after the edge that accepts the command.
module tb_debug_cmd_sequencer;

    logic        clk;
    logic        i_reset;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic [2:0]  i_cmd;
    logic [31:0] i_cmd_addr;
    logic [31:0] i_cmd_data;
    logic [31:0] o_gpio;
    logic [31:0] i_gpio;
    logic        o_busy;
    logic        o_done;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;

    logic [31:0] model_val;
    int          n_cmp;
    int          n_err;

    debug_cmd_sequencer #(
        .NB_GPIO     (32),
        .HOLD_CYCLES (2)
    ) dut (
        .i_clock     (clk),
        .i_reset     (i_reset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd       (i_cmd),
        .i_cmd_addr  (i_cmd_addr),
        .i_cmd_data  (i_cmd_data),
        .o_gpio      (o_gpio),
        .i_gpio      (i_gpio),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Debug unit model: readback appears one cycle after a read opcode is shown
    always @(posedge clk) begin
        if (o_gpio[31] === 1'b1 &&
            (o_gpio[22:16] == 7'd24 || o_gpio[22:16] == 7'd29 || o_gpio[22:16] == 7'd30))
            i_gpio <= model_val;
        else
            i_gpio <= 32'h0;
    end

    // Waits (bounded) for ready, presents a command and returns just after the accept edge
    task automatic send_cmd(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                            input bit keep);
        int t;
        t = 0;
        @(negedge clk);
        while (o_cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (o_cmd_ready !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: o_cmd_ready=%b after %0d cycles, want 1", o_cmd_ready, t);
        end
        i_cmd       = c;
        i_cmd_addr  = a;
        i_cmd_data  = d;
        i_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd       = 3'd0;
        i_cmd_addr  = 32'h0;
        i_cmd_data  = 32'h0;
        model_val   = 32'h0;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_gpio, o_busy, o_done, o_rsp_valid, o_cmd_ready} !== {32'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_ctrl: got gpio=%h busy=%b done=%b rv=%b rdy=%b, want gpio=0 busy=0 done=0 rv=0 rdy=1",
                     o_gpio, o_busy, o_done, o_rsp_valid, o_cmd_ready);
        end
        n_cmp++;
        if (o_rsp_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rsp_data: got %h, want 00000000", o_rsp_data);
        end
    endtask

    task automatic test_load_instr();
        logic [31:0] w [0:5] = '{32'h800F0004, 32'h80100000, 32'h80110010,
                                 32'h80128C22, 32'h80130000, 32'h80140000};
        logic [31:0] eg;
        logic        ed, er;
        send_cmd(3'd0, 32'h00000004, 32'h8C220010, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            eg = (c <= 18 && ((c - 1) % 3) != 2) ? w[(c - 1) / 3] : 32'h0;
            ed = (c == 19);
            er = (c == 20);
            n_cmp++;
            if ({o_gpio, o_done, o_rsp_valid, o_cmd_ready, o_busy} !== {eg, ed, 1'b0, er, ~er}) begin
                n_err++;
                $display("FAIL load_instr c=%0d: got gpio=%h done=%b rv=%b rdy=%b busy=%b, want gpio=%h done=%b rv=0 rdy=%b busy=%b",
                         c, o_gpio, o_done, o_rsp_valid, o_cmd_ready, o_busy, eg, ed, er, ~er);
            end
        end
    endtask

    task automatic test_read_reg();
        logic [31:0] w [0:1] = '{32'h80150005, 32'h80180000};
        logic [31:0] eg;
        logic        ed, er;
        model_val = 32'h12345678;
        // upper address bits must not leak into the register index word
        send_cmd(3'd1, 32'hFFFFFFE5, 32'h0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            eg = (c <= 6 && ((c - 1) % 3) != 2) ? w[(c - 1) / 3] : 32'h0;
            ed = (c == 7);
            er = (c == 8);
            n_cmp++;
            if ({o_gpio, o_done, o_rsp_valid, o_cmd_ready, o_busy} !== {eg, ed, ed, er, ~er}) begin
                n_err++;
                $display("FAIL read_reg c=%0d: got gpio=%h done=%b rv=%b rdy=%b busy=%b, want gpio=%h done=%b rv=%b rdy=%b busy=%b",
                         c, o_gpio, o_done, o_rsp_valid, o_cmd_ready, o_busy, eg, ed, ed, er, ~er);
            end
            if (c == 7) begin
                n_cmp++;
                if (o_rsp_data !== 32'h12345678) begin
                    n_err++;
                    $display("FAIL read_reg_data: got %h, want 12345678", o_rsp_data);
                end
            end
        end
    endtask

    task automatic test_read_mem_latched();
        logic [31:0] w [0:2] = '{32'h80160020, 32'h80170001, 32'h801D0000};
        logic [31:0] eg;
        logic        ed, er;
        model_val = 32'hDEADBEEF;
        send_cmd(3'd2, 32'h00010020, 32'h0, 1'b0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            eg = (c <= 9 && ((c - 1) % 3) != 2) ? w[(c - 1) / 3] : 32'h0;
            ed = (c == 10);
            er = (c == 11);
            n_cmp++;
            if ({o_gpio, o_done, o_rsp_valid, o_cmd_ready, o_busy} !== {eg, ed, ed, er, ~er}) begin
                n_err++;
                $display("FAIL read_mem c=%0d: got gpio=%h done=%b rv=%b rdy=%b busy=%b, want gpio=%h done=%b rv=%b rdy=%b busy=%b",
                         c, o_gpio, o_done, o_rsp_valid, o_cmd_ready, o_busy, eg, ed, ed, er, ~er);
            end
            if (c == 10) begin
                n_cmp++;
                if (o_rsp_data !== 32'hDEADBEEF) begin
                    n_err++;
                    $display("FAIL read_mem_data: got %h, want deadbeef", o_rsp_data);
                end
            end
            // scramble the command inputs and request a new command while busy
            if (c == 2) begin
                i_cmd       = 3'd7;
                i_cmd_addr  = 32'hFFFFFFFF;
                i_cmd_data  = 32'hA5A5A5A5;
                i_cmd_valid = 1'b1;
            end
            if (c == 9) i_cmd_valid = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eg [0:17] = '{32'h800B0000, 32'h800B0000, 32'h0, 32'h800C0000, 32'h800C0000, 32'h0,
                                   32'h0, 32'h0, 32'h800D0000, 32'h800D0000, 32'h0, 32'h0,
                                   32'h0, 32'h800E0000, 32'h800E0000, 32'h0, 32'h0, 32'h0};
        logic ed, er;
        int   n_done;
        n_done = 0;
        send_cmd(3'd4, 32'h0, 32'h0, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            ed = (k == 7 || k == 12 || k == 17);
            er = (k == 8 || k == 13 || k == 18);
            if (o_done === 1'b1) n_done++;
            n_cmp++;
            if ({o_gpio, o_done, o_rsp_valid, o_cmd_ready, o_busy} !== {eg[k-1], ed, 1'b0, er, ~er}) begin
                n_err++;
                $display("FAIL back_to_back k=%0d: got gpio=%h done=%b rv=%b rdy=%b busy=%b, want gpio=%h done=%b rv=0 rdy=%b busy=%b",
                         k, o_gpio, o_done, o_rsp_valid, o_cmd_ready, o_busy, eg[k-1], ed, er, ~er);
            end
            if (k == 7)  i_cmd = 3'd5;
            if (k == 12) i_cmd = 3'd6;
            if (k == 17) i_cmd_valid = 1'b0;
        end
        n_cmp++;
        if (n_done != 3) begin
            n_err++;
            $display("FAIL back_to_back_done_count: got %0d, want 3", n_done);
        end
        n_cmp++;
        if (o_rsp_data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rsp_data_hold: got %h, want deadbeef", o_rsp_data);
        end
    endtask

    task automatic test_short_cmds();
        logic [31:0] w [0:1] = '{32'h801F0000, 32'h80200000};
        logic [31:0] eg;
        logic        ed, er;
        model_val = 32'hCAFEF00D;
        send_cmd(3'd3, 32'h0, 32'h0, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            eg = (c <= 2) ? 32'h801E0000 : 32'h0;
            ed = (c == 4);
            er = (c == 5);
            n_cmp++;
            if ({o_gpio, o_done, o_rsp_valid, o_cmd_ready} !== {eg, ed, ed, er}) begin
                n_err++;
                $display("FAIL read_pc c=%0d: got gpio=%h done=%b rv=%b rdy=%b, want gpio=%h done=%b rv=%b rdy=%b",
                         c, o_gpio, o_done, o_rsp_valid, o_cmd_ready, eg, ed, ed, er);
            end
        end
        n_cmp++;
        if (o_rsp_data !== 32'hCAFEF00D) begin
            n_err++;
            $display("FAIL read_pc_data: got %h, want cafef00d", o_rsp_data);
        end
        send_cmd(3'd7, 32'h0, 32'h0, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            eg = (c <= 6 && ((c - 1) % 3) != 2) ? w[(c - 1) / 3] : 32'h0;
            ed = (c == 7);
            er = (c == 8);
            n_cmp++;
            if ({o_gpio, o_done, o_rsp_valid, o_cmd_ready} !== {eg, ed, 1'b0, er}) begin
                n_err++;
                $display("FAIL reset_cpu c=%0d: got gpio=%h done=%b rv=%b rdy=%b, want gpio=%h done=%b rv=0 rdy=%b",
                         c, o_gpio, o_done, o_rsp_valid, o_cmd_ready, eg, ed, er);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n_bad;
        n_bad = 0;
        send_cmd(3'd0, 32'h00000100, 32'h11223344, 1'b0);
        repeat (7) @(negedge clk);
        n_cmp++;
        if (o_gpio !== 32'h80113344) begin
            n_err++;
            $display("FAIL reset_mid_pre: got gpio=%h, want 80113344", o_gpio);
        end
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        n_cmp++;
        if ({o_gpio, o_busy, o_cmd_ready, o_done, o_rsp_valid, o_rsp_data} !==
            {32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_mid: got gpio=%h busy=%b rdy=%b done=%b rv=%b data=%h, want gpio=0 busy=0 rdy=1 done=0 rv=0 data=0",
                     o_gpio, o_busy, o_cmd_ready, o_done, o_rsp_valid, o_rsp_data);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (o_done !== 1'b0 || o_rsp_valid !== 1'b0 || o_gpio !== 32'h0) n_bad++;
        end
        n_cmp++;
        if (n_bad != 0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", n_bad);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        i_reset     = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd       = 3'd0;
        i_cmd_addr  = 32'h0;
        i_cmd_data  = 32'h0;
        model_val   = 32'h0;
        test_reset();
        test_load_instr();
        test_read_reg();
        test_read_mem_latched();
        test_back_to_back();
        test_short_cmds();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
